mem_stage: RTL

Memory-stage controller and MEM/WB pipeline register. It consumes the M-stage bundle produced by the EX/MEM register and performs the load or store on a word-wide data-memory bus with a ready handshake. While an access is outstanding it stalls the upstream pipeline, and it presents the W-stage bundle to the register file. Misaligned addresses and bus timeouts are reported on a sticky error flag.

---
 rtl/mem_stage_pkg.sv | 21 ++
 rtl/mem_stage_if.sv | 22 ++
 rtl/mem_stage.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, writeback-source encodings and FSM states for the memory stage.
package mem_stage_pkg;

   localparam int WORD_WIDTH     = 32;
   localparam int REG_SIZE       = 5;
   localparam int REG_SRC_LENGTH = 2;

   localparam logic [WORD_WIDTH-1:0]     ZERO_WORD   = 32'h0000_0000;
   localparam logic [REG_SRC_LENGTH-1:0] REG_SRC_MEM = 2'b01;

   typedef enum logic [0:0] {
      MS_IDLE   = 1'b0,
      MS_ACCESS = 1'b1
   } msState_t;

   function automatic logic isMemOp(input logic dataWe,
                                    input logic [REG_SRC_LENGTH-1:0] regSrc);
      return dataWe | (regSrc == REG_SRC_MEM);
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Word-wide data-memory bus with a ready handshake.
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic                  mem_req;
   logic                  mem_we;
   logic [WORD_WIDTH-1:0] mem_addr;
   logic [WORD_WIDTH-1:0] mem_wdata;
   logic                  mem_ready;
   logic [WORD_WIDTH-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ready, mem_rdata
   );

endinterface

// File: rtl/mem_stage.sv
// Memory-stage controller: drives the data bus, stalls upstream while waiting,
// flags misaligned/timed-out accesses and holds the MEM/WB register.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      Regfile_weM,
   input  logic                      DataMem_weM,
   input  logic [REG_SIZE-1:0]       writeRegAddrM,
   input  logic [REG_SRC_LENGTH-1:0] regSrc_muxM,
   input  logic [WORD_WIDTH-1:0]     aluOutM,
   input  logic [WORD_WIDTH-1:0]     writeDataM,
   mem_stage_if.master               bus,
   output logic                      stallM,
   output logic                      memErr,
   output logic                      Regfile_weW,
   output logic [REG_SIZE-1:0]       writeRegAddrW,
   output logic [WORD_WIDTH-1:0]     regWriteDataW
);

   localparam int CNT_W = $clog2(TIMEOUT);

   msState_t         state;
   msState_t         stateNext;
   logic [CNT_W-1:0] waitCnt;
   logic [CNT_W-1:0] waitCntNext;
   logic             memOp;
   logic             misaligned;
   logic             errNow;
   logic             stallRaw;
   logic             reqS;
   logic             weS;
   logic [WORD_WIDTH-1:0] addrS;
   logic [WORD_WIDTH-1:0] wdataS;

   // Next-state, wait counter, stall and bus drive
   always_comb begin
      memOp       = isMemOp(DataMem_weM, regSrc_muxM);
      misaligned  = (aluOutM[1:0] != 2'b00);
      stateNext   = state;
      waitCntNext = waitCnt;
      errNow      = 1'b0;
      stallRaw    = 1'b0;
      reqS        = 1'b0;
      weS         = 1'b0;
      addrS       = ZERO_WORD;
      wdataS      = ZERO_WORD;
      case (state)
         MS_IDLE: begin
            waitCntNext = {CNT_W{1'b0}};
            if (memOp && !misaligned) begin
               stateNext = MS_ACCESS;
               stallRaw  = 1'b1;
            end else if (memOp) begin
               errNow = 1'b1;
            end else begin
               stateNext = MS_IDLE;
            end
         end
         MS_ACCESS: begin
            reqS   = 1'b1;
            weS    = DataMem_weM;
            addrS  = aluOutM;
            wdataS = writeDataM;
            // ready takes priority over an expiring timeout in the same cycle
            if (bus.mem_ready) begin
               stateNext   = MS_IDLE;
               waitCntNext = {CNT_W{1'b0}};
            end else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
               errNow      = 1'b1;
               stateNext   = MS_IDLE;
               waitCntNext = {CNT_W{1'b0}};
            end else begin
               stallRaw    = 1'b1;
               waitCntNext = waitCnt + CNT_W'(1);
            end
         end
         default: begin
            stateNext   = MS_IDLE;
            waitCntNext = {CNT_W{1'b0}};
         end
      endcase
   end

   // Stall must read low while reset is held, even with a memory op presented
   assign stallM        = rst & stallRaw;
   assign bus.mem_req   = reqS;
   assign bus.mem_we    = weS;
   assign bus.mem_addr  = addrS;
   assign bus.mem_wdata = wdataS;

   // FSM state, wait counter and sticky error
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= MS_IDLE;
         waitCnt <= {CNT_W{1'b0}};
         memErr  <= 1'b0;
      end else begin
         state   <= stateNext;
         waitCnt <= waitCntNext;
         memErr  <= memErr | errNow;
      end
   end

   // MEM/WB register: bubble while stalled, otherwise capture the retiring instruction
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         Regfile_weW   <= 1'b0;
         writeRegAddrW <= {REG_SIZE{1'b0}};
         regWriteDataW <= ZERO_WORD;
      end else if (stallM) begin
         Regfile_weW   <= 1'b0;
      end else begin
         Regfile_weW   <= Regfile_weM & ~errNow;
         writeRegAddrW <= writeRegAddrM;
         regWriteDataW <= (regSrc_muxM == REG_SRC_MEM) ? bus.mem_rdata : aluOutM;
      end
   end

endmodule
